ps2_rx: RTL and testbench

//  System-clock PS/2 frame receiver, directly upstream of the keyboard matrix decoder.

---
 rtl/ps2_rx.sv | 142 ++++++++++++++
 tb/tb_ps2_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: synchronise, de-glitch, deserialise, validate
// Emits each good scan-code byte as a one-cycle strobe and flags discarded frames.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int TO_W        = 13
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2clk,
  input  logic       ps2dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f, clk_f_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state, state_nxt;
  logic [7:0]    sr, sr_nxt;
  logic [2:0]    bitcnt, bitcnt_nxt;
  logic          par_ok, par_ok_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt, err_nxt;

  // Filtered clock only follows the synchronised input after a run of FILTER_LEN differing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_f    <= 1'b1;
      clk_f_d  <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1  <= ps2clk;
      clk_s2  <= clk_s1;
      dat_s1  <= ps2dat;
      dat_s2  <= dat_s1;
      clk_f_d <= clk_f;
      if (clk_s2 != clk_f) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_f    <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = clk_f_d & ~clk_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sr       <= '0;
      bitcnt   <= '0;
      par_ok   <= 1'b0;
      to_cnt   <= '0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      bitcnt   <= bitcnt_nxt;
      par_ok   <= par_ok_nxt;
      to_cnt   <= to_cnt_nxt;
      rx_data  <= data_nxt;
      rx_valid <= valid_nxt;
      rx_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sr_nxt     = sr;
    bitcnt_nxt = bitcnt;
    par_ok_nxt = par_ok;
    to_cnt_nxt = to_cnt;
    data_nxt   = rx_data;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;

    if (state == IDLE || fall) begin
      to_cnt_nxt = '0;
    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
      state_nxt  = IDLE;
      err_nxt    = 1'b1;
      to_cnt_nxt = '0;
    end else begin
      to_cnt_nxt = to_cnt + 1'b1;
    end

    // A fall always overrides a coincident timeout.
    if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_nxt  = DATA;
            bitcnt_nxt = '0;
          end
        end
        DATA: begin
          sr_nxt     = {dat_s2, sr[7:1]};
          bitcnt_nxt = bitcnt + 1'b1;
          if (bitcnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_ok_nxt = ^sr ^ dat_s2;
          state_nxt  = STOP;
        end
        STOP: begin
          if (dat_s2 && par_ok) begin
            data_nxt  = sr;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - scoreboard bench for ps2_rx
`timescale 1ns/1ps
module tb_ps2_rx;

  localparam int FL   = 8;
  localparam int TC   = 5000;
  localparam int TO_W = 13;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2clk = 1'b1;
  logic       ps2dat = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, busy;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TC), .TO_W(TO_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2clk   (ps2clk),
    .ps2dat   (ps2dat),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_err; logic [7:0] data;} exp_t;
  exp_t sb[$];

  int         chk_cnt = 0;
  int         err_cnt = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  int         err_seen_cyc = -1;
  logic [7:0] last_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && (rx_valid || rx_err)) begin
      check("strobe_exclusive", {31'b0, rx_valid & rx_err}, 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'b0, rx_valid, rx_err}, 0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", {31'b0, rx_err}, {31'b0, e.is_err});
        if (!e.is_err) last_data = e.data;
        check("rx_data", {24'b0, rx_data}, {24'b0, last_data});
        if (rx_err) err_seen_cyc = cyc;
      end
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2dat = bits[i];
      repeat (HALF) @(negedge clk);
      ps2clk   = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2clk = 1'b1;
    end
    ps2dat = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < TC + 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_busy_idle"}, {31'b0, busy}, 0);
  endtask

  initial begin : stim
    int  n;
    int  diff;
    bit  busy_seen;

    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'b0, rx_data}, 0);
    check("reset_rx_valid", {31'b0, rx_valid}, 0);
    check("reset_rx_err", {31'b0, rx_err}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    sb.push_back('{1'b0, 8'h1C});
    send_bits(mk(8'h1C, 0, 0), 11);
    drain("t1");

    sb.push_back('{1'b0, 8'hF0});
    sb.push_back('{1'b0, 8'h1C});
    send_bits(mk(8'hF0, 0, 0), 11);
    send_bits(mk(8'h1C, 0, 0), 11);
    drain("t2");

    sb.push_back('{1'b1, 8'h00});
    send_bits(mk(8'h5A, 1, 0), 11);
    drain("t3");

    sb.push_back('{1'b1, 8'h00});
    send_bits(mk(8'h29, 0, 1), 11);
    drain("t4");

    ps2clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2clk = 1'b1;
    busy_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    check("glitch_busy", {31'b0, busy_seen}, 0);

    err_seen_cyc = -1;
    sb.push_back('{1'b1, 8'h00});
    send_bits(mk(8'h33, 0, 0), 6);
    n = 0;
    while (err_seen_cyc < 0 && n < TC + 500) begin
      @(negedge clk);
      n++;
    end
    diff = err_seen_cyc - fall_cyc;
    // Sync (2) plus filter (FL) plus fall register sits between the driven edge and the internal fall.
    check("timeout_latency_ok", {31'b0, (diff >= TC + FL + 2) && (diff <= TC + FL + 4)}, 1);
    if (!((diff >= TC + FL + 2) && (diff <= TC + FL + 4)))
      $display("  timeout latency measured %0d cycles", diff);
    drain("t5a");

    sb.push_back('{1'b0, 8'h76});
    send_bits(mk(8'h76, 0, 0), 11);
    drain("t5b");

    send_bits(mk(8'h12, 0, 0), 5);
    check("t6_busy_mid", {31'b0, busy}, 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_rx_data", {24'b0, rx_data}, 0);
    check("t6_rst_rx_valid", {31'b0, rx_valid}, 0);
    check("t6_rst_rx_err", {31'b0, rx_err}, 0);
    check("t6_rst_busy", {31'b0, busy}, 0);
    last_data = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    sb.push_back('{1'b0, 8'h12});
    send_bits(mk(8'h12, 0, 0), 11);
    drain("t6");
    check("final_rx_data", {24'b0, rx_data}, 32'h12);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", chk_cnt);
    $fatal(1);
  end

endmodule
